demux_36_loader: RTL and testbench
==================================

# demux_36_loader

Serial-to-parallel demultiplexer: the write-side counterpart of the 36-way selector mux in the CNN datapath. It accepts one INPUT_DATA_WIDTH-bit word per handshake and writes it into the slot named by an internal index counter, filling slots 0..NUM_OUTPUTS-1 in order. When all slots hold fresh data, it presents them as one parallel block and holds it until the consumer acknowledges. It sits between the pixel/weight memory stream and the 6x6 window registers that feed the MAC array.

## Interface
- INPUT_DATA_WIDTH, 8, width of one word/slot
- NUM_OUTPUTS, 36, number of slots per block; range 2..2^BITWIDTH_SEL
- BITWIDTH_SEL, 9, width of the slot index
- CLOCK_50  in  1  sole clock, rising edge
- RESET_InLow  in  1  reset, asynchronous, active-low
- DEMUX_clear  in  1  synchronous abort/flush
- DEMUX_In  in  INPUT_DATA_WIDTH  input word
- DEMUX_In_valid  in  1  DEMUX_In is valid this cycle
- DEMUX_In_ready  out  1  block can accept a word this cycle
- DEMUX_Out  out  NUM_OUTPUTS*INPUT_DATA_WIDTH  flat slot bus; slot k = bits [(k+1)*W-1 : k*W]
- DEMUX_Out_valid  out  1  all slots loaded, block available
- DEMUX_Out_ack  in  1  consumer has taken the block
- DEMUX_index  out  BITWIDTH_SEL  slot to be written by the next accept

## Operation
- States: LOAD, FULL.
- Reset: state LOAD, index 0, all slots 0, Out_valid 0, In_ready 1.
- LOAD: In_ready = 1. Accept = In_valid & In_ready. On accept: slot[index] <= DEMUX_In, and index +1, except when index == NUM_OUTPUTS-1: index <= 0 and state -> FULL.
- FULL: In_ready = 0, Out_valid = 1. Slots frozen. DEMUX_Out_ack -> state LOAD. Index is already 0.
- Ack while in LOAD: ignored.
- In_valid while in FULL: no accept. The word is held by the producer.
- Ack and In_valid asserted together in FULL: the ack is taken. No word is accepted that cycle, because In_ready is 0. The first new accept happens the following cycle.
- Slots are not cleared on ack. The previous block stays visible until it is overwritten slot by slot.
- DEMUX_clear, from any state: state LOAD, index 0, all slots 0, Out_valid 0. It has priority over accept and ack in the same cycle.
- Index never exceeds NUM_OUTPUTS-1. Slot decode for indices outside that range never fires.
- Reset asserted mid-block: immediate return to the reset values. The partial block is discarded.

## Timing
- All outputs are registered except In_ready, which is decoded from state only. There is no combinational path from any input to any output.
- An accept at edge t makes the slot visible on DEMUX_Out after edge t, and advances DEMUX_index after the same edge.
- Out_valid rises on the edge that accepts word NUM_OUTPUTS-1.
- Out_valid falls on the edge that samples ack.
- Minimum block period is NUM_OUTPUTS+1 cycles: NUM_OUTPUTS accepts plus 1 ack cycle.
- Throughput in LOAD is one word per cycle. Gaps in In_valid stall the index without side effects.

## Structure
- Shared package holds:
  - state encoding localparams (LOAD=1'b0, FULL=1'b1);
  - the defaults NUM_OUTPUTS=36, INPUT_DATA_WIDTH=8, BITWIDTH_SEL=9, also used by the selector mux;
  - a slot-offset function (k*INPUT_DATA_WIDTH).
- One sub-module, demux_index_counter: wrapping up-counter with inc, clear and terminal-count outputs.
- The slot array and the FSM stay in the top module. The slot array uses a generate loop with a per-slot write enable, (index == k) & accept.

## Test plan
- Reset, then 36 consecutive words 0x01..0x24 with In_valid held high:
  - slot k = k+1;
  - Out_valid rises the cycle after the 36th accept;
  - In_ready = 0, index = 0.
- In FULL, hold In_valid with data 0xAA for 5 cycles, then ack:
  - no slot changes;
  - Out_valid falls after the ack edge;
  - 0xAA is written to slot 0 on the next cycle.
- Toggle In_valid randomly (50%) across one block:
  - slots match the accepted words in order;
  - index advances only on accepts.
- Load 20 words, then pulse DEMUX_clear together with In_valid:
  - all slots 0, index 0, no write that cycle.
- Load 10 words, then assert RESET_InLow low mid-cycle:
  - outputs go to reset values immediately, without waiting for a clock edge.
- Parameter override NUM_OUTPUTS=9, BITWIDTH_SEL=4:
  - after 9 words, Out_valid = 1 and index wraps to 0;
  - the upper bus width equals 9*8 bits.

Source files
------------

// File: rtl/demux_36_loader_pkg.sv
// Shared defaults, state encoding and slot helpers for the
// serial-to-parallel window loader and its selector mux.
package demux_36_loader_pkg;

    localparam int DEF_INPUT_DATA_WIDTH = 8;
    localparam int DEF_NUM_OUTPUTS      = 36;
    localparam int DEF_BITWIDTH_SEL     = 9;

    localparam logic ST_LOAD = 1'b0;
    localparam logic ST_FULL = 1'b1;

    typedef enum logic {
        LOAD = ST_LOAD,
        FULL = ST_FULL
    } state_e;

    function automatic int unsigned slot_offset(
        input int unsigned k,
        input int unsigned w
    );
        return k * w;
    endfunction

endpackage

// File: rtl/demux_36_loader_if.sv
// Word-in / block-out handshake bundle of the window loader.
interface demux_36_loader_if #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int NUM_OUTPUTS      = 36,
    parameter int BITWIDTH_SEL     = 9
);

    logic [INPUT_DATA_WIDTH-1:0]             DEMUX_In;
    logic                                    DEMUX_In_valid;
    logic                                    DEMUX_In_ready;
    logic [NUM_OUTPUTS*INPUT_DATA_WIDTH-1:0] DEMUX_Out;
    logic                                    DEMUX_Out_valid;
    logic                                    DEMUX_Out_ack;
    logic [BITWIDTH_SEL-1:0]                 DEMUX_index;

    modport master (
        output DEMUX_In,
        output DEMUX_In_valid,
        input  DEMUX_In_ready,
        input  DEMUX_Out,
        input  DEMUX_Out_valid,
        output DEMUX_Out_ack,
        input  DEMUX_index
    );

    modport slave (
        input  DEMUX_In,
        input  DEMUX_In_valid,
        output DEMUX_In_ready,
        output DEMUX_Out,
        output DEMUX_Out_valid,
        input  DEMUX_Out_ack,
        output DEMUX_index
    );

endinterface

// File: rtl/demux_36_loader_counter.sv
// Wrapping slot index counter: 0..MAX, clear has priority over inc.
module demux_index_counter #(
    parameter int WIDTH = 9,
    parameter int MAX   = 35
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc_o    = (count_q == WIDTH'(MAX));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/demux_36_loader.sv
// Fills NUM_OUTPUTS slots one word per handshake and holds the
// completed block until the consumer acknowledges it.
module demux_36_loader
    import demux_36_loader_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = DEF_INPUT_DATA_WIDTH,
    parameter int NUM_OUTPUTS      = DEF_NUM_OUTPUTS,
    parameter int BITWIDTH_SEL     = DEF_BITWIDTH_SEL
) (
    input logic               CLOCK_50,
    input logic               RESET_InLow,
    input logic               DEMUX_clear,
    demux_36_loader_if.slave  bus
);

    state_e                  state_q;
    state_e                  state_d;
    logic                    out_valid_q;
    logic                    in_ready;
    logic                    accept;
    logic                    tc;
    logic [BITWIDTH_SEL-1:0] index;

    assign in_ready = (state_q == LOAD);
    assign accept   = bus.DEMUX_In_valid & in_ready;

    demux_index_counter #(
        .WIDTH (BITWIDTH_SEL),
        .MAX   (NUM_OUTPUTS - 1)
    ) u_index (
        .clk     (CLOCK_50),
        .rst_n   (RESET_InLow),
        .inc_i   (accept),
        .clr_i   (DEMUX_clear),
        .count_o (index),
        .tc_o    (tc)
    );

    always_comb begin
        state_d = state_q;
        if (DEMUX_clear) begin
            state_d = LOAD;
        end else begin
            unique case (state_q)
                LOAD: if (accept && tc) state_d = FULL;
                FULL: if (bus.DEMUX_Out_ack) state_d = LOAD;
                default: state_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            state_q     <= LOAD;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == FULL);
        end
    end

    // Slots keep the previous block after ack until each is overwritten.
    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_slot
        logic                        we;
        logic [INPUT_DATA_WIDTH-1:0] slot_q;

        assign we = accept & (index == BITWIDTH_SEL'(k));

        always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
            if (!RESET_InLow) begin
                slot_q <= '0;
            end else if (DEMUX_clear) begin
                slot_q <= '0;
            end else if (we) begin
                slot_q <= bus.DEMUX_In;
            end
        end

        assign bus.DEMUX_Out[slot_offset(k, INPUT_DATA_WIDTH) +: INPUT_DATA_WIDTH] = slot_q;
    end

    assign bus.DEMUX_In_ready  = in_ready;
    assign bus.DEMUX_Out_valid = out_valid_q;
    assign bus.DEMUX_index     = index;

endmodule

// File: tb/tb_demux_36_loader.sv
// Directed and randomized bench for the window loader, checked
// against a block-level slot model kept in the bench.
module tb_demux_36_loader;

    localparam int W  = 8;
    localparam int N  = 36;
    localparam int S  = 9;
    localparam int N2 = 9;
    localparam int S2 = 4;
    localparam int BW = N * W;

    typedef logic [BW-1:0] bus_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic clr2  = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_slot [N];
    int         m_cnt;
    logic [7:0] s_slot [N2];

    demux_36_loader_if #(.INPUT_DATA_WIDTH(W), .NUM_OUTPUTS(N), .BITWIDTH_SEL(S)) bus ();
    demux_36_loader_if #(.INPUT_DATA_WIDTH(W), .NUM_OUTPUTS(N2), .BITWIDTH_SEL(S2)) sbus ();

    demux_36_loader #(
        .INPUT_DATA_WIDTH (W),
        .NUM_OUTPUTS      (N),
        .BITWIDTH_SEL     (S)
    ) dut (
        .CLOCK_50    (clk),
        .RESET_InLow (rst_n),
        .DEMUX_clear (clr),
        .bus         (bus)
    );

    demux_36_loader #(
        .INPUT_DATA_WIDTH (W),
        .NUM_OUTPUTS      (N2),
        .BITWIDTH_SEL     (S2)
    ) dut_small (
        .CLOCK_50    (clk),
        .RESET_InLow (rst_n),
        .DEMUX_clear (clr2),
        .bus         (sbus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input bus_t obs, input bus_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bus_t m_pack();
        bus_t r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = m_slot[k];
        return r;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < N; k++) m_slot[k] = 8'h00;
        m_cnt = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " out"},   bus.DEMUX_Out, m_pack());
        chk({tag, " valid"}, bus_t'(bus.DEMUX_Out_valid), bus_t'(m_cnt == N));
        chk({tag, " ready"}, bus_t'(bus.DEMUX_In_ready), bus_t'(m_cnt != N));
        chk({tag, " index"}, bus_t'(bus.DEMUX_index), bus_t'(m_cnt % N));
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic step(
        input logic       v,
        input logic [7:0] d,
        input logic       ack,
        input logic       c,
        input string      tag
    );
        bus.DEMUX_In_valid = v;
        bus.DEMUX_In       = d;
        bus.DEMUX_Out_ack  = ack;
        clr                = c;
        @(posedge clk);
        #1;
        if (c) begin
            m_reset();
        end else if (m_cnt < N) begin
            if (v) begin
                m_slot[m_cnt] = d;
                m_cnt++;
            end
        end else if (ack) begin
            m_cnt = 0;
        end
        check_model(tag);
    endtask

    initial begin
        int   guard;
        bus_t sexp;

        bus.DEMUX_In = '0;
        bus.DEMUX_In_valid = 1'b0;
        bus.DEMUX_Out_ack = 1'b0;
        sbus.DEMUX_In = '0;
        sbus.DEMUX_In_valid = 1'b0;
        sbus.DEMUX_Out_ack = 1'b0;
        m_reset();

        #3;
        check_model("reset");
        chk("small reset valid", bus_t'(sbus.DEMUX_Out_valid), bus_t'(0));
        chk("small reset ready", bus_t'(sbus.DEMUX_In_ready), bus_t'(1));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0, "fill");
        chk("fill slot0", bus_t'(bus.DEMUX_Out[7:0]), bus_t'(8'h01));
        chk("fill slot35", bus_t'(bus.DEMUX_Out[35*8 +: 8]), bus_t'(8'h24));
        chk("fill valid", bus_t'(bus.DEMUX_Out_valid), bus_t'(1));

        for (int i = 0; i < 5; i++) step(1'b1, 8'hAA, 1'b0, 1'b0, "hold");
        step(1'b1, 8'hAA, 1'b1, 1'b0, "ack");
        chk("ack slot0 kept", bus_t'(bus.DEMUX_Out[7:0]), bus_t'(8'h01));
        step(1'b1, 8'hAA, 1'b0, 1'b0, "post ack");
        chk("post ack slot0", bus_t'(bus.DEMUX_Out[7:0]), bus_t'(8'hAA));

        guard = 0;
        while (m_cnt < N && guard < 400) begin
            step(1'($urandom), 8'($urandom), 1'b0, 1'b0, "rand");
            guard++;
        end
        chk("rand budget", bus_t'(m_cnt == N), bus_t'(1));
        step(1'b0, 8'h00, 1'b1, 1'b0, "ack2");

        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "pre clear");
        step(1'b1, 8'h5C, 1'b0, 1'b1, "clear");
        chk("clear out", bus.DEMUX_Out, bus_t'(0));

        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "pre rst");
        bus.DEMUX_In_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_model("async rst");
        chk("async rst out", bus.DEMUX_Out, bus_t'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N2; i++) begin
            s_slot[i] = 8'($urandom);
            sbus.DEMUX_In_valid = 1'b1;
            sbus.DEMUX_In = s_slot[i];
            @(posedge clk);
            #1;
            chk("small index", bus_t'(sbus.DEMUX_index), bus_t'((i + 1) % N2));
            chk("small valid", bus_t'(sbus.DEMUX_Out_valid), bus_t'(i == N2 - 1));
        end
        sbus.DEMUX_In_valid = 1'b0;
        sexp = '0;
        for (int k = 0; k < N2; k++) sexp[k*W +: W] = s_slot[k];
        chk("small out", bus_t'(sbus.DEMUX_Out), sexp);
        chk("small ready", bus_t'(sbus.DEMUX_In_ready), bus_t'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
